dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and access sequencer in front of the single data memory (`data_mem`). It shares the memory between the CPU memory stage (port 0) and a loader/debug port (port 1), latches each granted request, and drives the memory's read/write strobes for the required number of cycles. It returns a one-cycle `done` with captured read data to the winning requester, and supplies the CPU with a stall signal while its access is pending.

## Interface
Parameters:
- `RD_LAT`, default 1: data_mem read latency in cycles (1..7).
- `MAX_WAIT`, default 8: cycles port 1 may be refused before it is forced to win (1..255).

Ports:
- `im_clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `p0_req`, `p1_req` in 1: access request; held until `gnt`.
- `p0_we`, `p1_we` in 1: 1 = write, 0 = read.
- `p0_addr`, `p1_addr` in `WORD`: byte address.
- `p0_wdata`, `p1_wdata` in `WORD`: store data.
- `p0_gnt`, `p1_gnt` out 1: one-cycle grant pulse; request fields are sampled in this cycle.
- `p0_done`, `p1_done` out 1: one-cycle completion pulse.
- `p0_rdata`, `p1_rdata` out `WORD`: load data; valid when `done` is high after a read, and held until that port's next read completes.
- `cpu_stall` out 1: `p0_req & ~p0_done`.
- `mem_read`, `mem_write` out 1: data_mem strobes.
- `mem_addr`, `mem_wdata` out `WORD`: data_mem address and store data (the `alu_result` and `read_data2` equivalents).
- `mem_rdata` in `WORD`: data_mem `read_data`.

## Operation
- FSM states:
  - IDLE: if any request is present, arbitrate, pulse the winner's `gnt`, latch `we`/`addr`/`wdata`/port id, go to ISSUE.
  - ISSUE: write → `mem_write`=1 for this cycle only, go to RESP. Read → `mem_read`=1, load `lat_cnt`=`RD_LAT`-1, go to WAIT, or directly to RESP with `mem_rdata` captured when `RD_LAT`=1.
  - WAIT: `mem_read` stays high; decrement `lat_cnt`; at 0, capture `mem_rdata` into the winner's `rdata` register and go to RESP.
  - RESP: winner's `done`=1, go to IDLE. No grant is issued in RESP.
- Arbitration in IDLE:
  - Only one port requesting → that port wins.
  - Both requesting → port 1 wins if `wait_cnt` ≥ `MAX_WAIT`; otherwise the policy set under Configuration applies.
- `wait_cnt` (8 bit, saturating):
  - Increments in every cycle where `p1_req`=1 and `p1_gnt`=0.
  - Clears when `p1_gnt`=1 or `p1_req`=0.
- Request rules:
  - Request fields are ignored after `gnt`.
  - A requester may drop `req` before `gnt`; this has no effect.
  - A `req` still high after `done` is treated as a new request.
- Memory outputs outside ISSUE/WAIT: `mem_read`=`mem_write`=0. `mem_addr`/`mem_wdata` always show the latched values.
- Addresses and data pass through unmodified; there is no alignment check.

## Timing
- Grant in cycle T:
  - Write: `mem_write` at T+1, `done` at T+2.
  - Read: `mem_read` from T+1 through T+`RD_LAT`, `done` with `rdata` at T+`RD_LAT`+1.
- Next grant no earlier than the cycle after RESP. Peak throughput is one write per 3 cycles.
- Reset values: state IDLE; all `gnt`/`done`/`mem_read`/`mem_write`/`cpu_stall` 0; `rdata`, `mem_addr`, `mem_wdata`, `wait_cnt` 0; round-robin pointer set so port 0 wins first.
- Reset mid-transaction: strobes drop immediately (asynchronous). The transaction is abandoned with no `done`, and the requester must re-request.
- Simultaneous requests with `wait_cnt` saturated: the forced grant overrides both policies.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin. On contention, the port not granted last wins. The pointer updates on every grant.
- Undefined: fixed priority. Port 0 wins on contention; the `MAX_WAIT` force is the only route for port 1 under contention. The round-robin pointer is not built.

## Structure
- `definitions.vh`: `WORD` (existing); FSM state encodings `ARB_IDLE`, `ARB_ISSUE`, `ARB_WAIT`, `ARB_RESP`; port ids `ARB_P0`, `ARB_P1`.
- Sub-module `arb_pick`: purely combinational.
  - Inputs: two requests, `wait_cnt` saturation flag, round-robin pointer.
  - Outputs: one-hot winner.
- Estimated size: about 200 lines of RTL.

## Test plan
- Port-0 write, `RD_LAT`=1, addr 0x10, data 0xDEAD → `p0_gnt` at T, `mem_write`=1 with addr 0x10 at T+1, `p0_done` at T+2. A following port-0 read of 0x10 returns 0xDEAD at `done`.
- Read with `RD_LAT`=3 → `mem_read` high for exactly 3 cycles, `p1_done` at T+4, `p1_rdata` equal to `mem_rdata` in the last WAIT cycle.
- Both ports requesting continuously, macro undefined, `MAX_WAIT`=4 → port 0 wins until `wait_cnt` reaches 4, then port 1 wins once, then `wait_cnt`=0.
- Both ports requesting continuously, `DMEM_ARB_RR_EN` defined → grants alternate 0,1,0,1, starting with port 0 after reset.
- `reset` asserted in WAIT → `mem_read` is 0 in the same cycle, no `done`, state IDLE. A re-request completes normally.
- `p0_req` held during a port-1 access → `cpu_stall`=1 throughout, clearing only in the `p0_done` cycle.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared word width, FSM state and port id encodings for dmem_arbiter
package dmem_arbiter_pkg;

  localparam int WORD = 32;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    ARB_P0 = 1'b0,
    ARB_P1 = 1'b1
  } arb_port_t;

endpackage

// File: rtl/dmem_arbiter_pick.sv
// rtl/dmem_arbiter_pick.sv - combinational two-port winner select (arb_pick)
// Round-robin tie-break when DMEM_ARB_RR_EN is defined, fixed port-0 priority otherwise.
module arb_pick (
  input  logic       req0,
  input  logic       req1,
  input  logic       force1,
`ifdef DMEM_ARB_RR_EN
  input  logic       rr_ptr,
`endif
  output logic [1:0] win
);

  always_comb begin
    win = 2'b00;
    if (req0 && req1) begin
      if (force1) begin
        win = 2'b10;
      end else begin
`ifdef DMEM_ARB_RR_EN
        // rr_ptr high means port 0 was granted last, so port 1 gets the tie
        win = rr_ptr ? 2'b10 : 2'b01;
`else
        win = 2'b01;
`endif
      end
    end else if (req0) begin
      win = 2'b01;
    end else if (req1) begin
      win = 2'b10;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data memory arbiter and access sequencer
// Optional round-robin arbitration under DMEM_ARB_RR_EN; fixed port-0 priority otherwise.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 8
) (
  input  logic            im_clk,
  input  logic            reset,
  input  logic            p0_req,
  input  logic            p0_we,
  input  logic [WORD-1:0] p0_addr,
  input  logic [WORD-1:0] p0_wdata,
  input  logic            p1_req,
  input  logic            p1_we,
  input  logic [WORD-1:0] p1_addr,
  input  logic [WORD-1:0] p1_wdata,
  output logic            p0_gnt,
  output logic            p1_gnt,
  output logic            p0_done,
  output logic            p1_done,
  output logic [WORD-1:0] p0_rdata,
  output logic [WORD-1:0] p1_rdata,
  output logic            cpu_stall,
  output logic            mem_read,
  output logic            mem_write,
  output logic [WORD-1:0] mem_addr,
  output logic [WORD-1:0] mem_wdata,
  input  logic [WORD-1:0] mem_rdata
);

  localparam logic [2:0] LAT_LOAD   = 3'(RD_LAT - 1);
  localparam logic [7:0] MAX_WAIT_W = 8'(MAX_WAIT);

  arb_state_t      state, state_nxt;
  arb_port_t       lat_port;
  logic            lat_we;
  logic [WORD-1:0] lat_addr;
  logic [WORD-1:0] lat_wdata;
  logic [2:0]      lat_cnt, lat_cnt_nxt;
  logic [7:0]      wait_cnt;
  logic [1:0]      win;
  logic            grant;
  logic            capture;
  logic            force1;

  assign force1 = (wait_cnt >= MAX_WAIT_W);
  assign grant  = (state == ARB_IDLE) && (win != 2'b00);

`ifdef DMEM_ARB_RR_EN
  logic rr_ptr;

  always_ff @(posedge im_clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= 1'b0;
    end else if (grant) begin
      rr_ptr <= win[0];
    end
  end

  arb_pick u_pick (
    .req0   (p0_req),
    .req1   (p1_req),
    .force1 (force1),
    .rr_ptr (rr_ptr),
    .win    (win)
  );
`else
  arb_pick u_pick (
    .req0   (p0_req),
    .req1   (p1_req),
    .force1 (force1),
    .win    (win)
  );
`endif

  always_comb begin
    state_nxt   = state;
    lat_cnt_nxt = lat_cnt;
    p0_gnt      = 1'b0;
    p1_gnt      = 1'b0;
    p0_done     = 1'b0;
    p1_done     = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    capture     = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (win != 2'b00) begin
          p0_gnt    = win[0];
          p1_gnt    = win[1];
          state_nxt = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (lat_we) begin
          mem_write = 1'b1;
          state_nxt = ARB_RESP;
        end else begin
          mem_read = 1'b1;
          if (RD_LAT == 1) begin
            capture   = 1'b1;
            state_nxt = ARB_RESP;
          end else begin
            lat_cnt_nxt = LAT_LOAD;
            state_nxt   = ARB_WAIT;
          end
        end
      end
      ARB_WAIT: begin
        mem_read    = 1'b1;
        lat_cnt_nxt = lat_cnt - 3'd1;
        // the read data is valid in the cycle the counter steps down to zero
        if (lat_cnt == 3'd1) begin
          capture   = 1'b1;
          state_nxt = ARB_RESP;
        end
      end
      ARB_RESP: begin
        p0_done   = (lat_port == ARB_P0);
        p1_done   = (lat_port == ARB_P1);
        state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge im_clk or posedge reset) begin
    if (reset) begin
      state     <= ARB_IDLE;
      lat_cnt   <= 3'd0;
      lat_port  <= ARB_P0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      state   <= state_nxt;
      lat_cnt <= lat_cnt_nxt;
      if (grant) begin
        lat_port  <= win[1] ? ARB_P1 : ARB_P0;
        lat_we    <= win[1] ? p1_we    : p0_we;
        lat_addr  <= win[1] ? p1_addr  : p0_addr;
        lat_wdata <= win[1] ? p1_wdata : p0_wdata;
      end
    end
  end

  always_ff @(posedge im_clk or posedge reset) begin
    if (reset) begin
      p0_rdata <= '0;
      p1_rdata <= '0;
    end else if (capture) begin
      if (lat_port == ARB_P1) begin
        p1_rdata <= mem_rdata;
      end else begin
        p0_rdata <= mem_rdata;
      end
    end
  end

  // starvation counter for port 1, saturating at 255
  always_ff @(posedge im_clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= 8'd0;
    end else if (p1_req && !p1_gnt) begin
      if (wait_cnt != 8'hFF) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end else begin
      wait_cnt <= 8'd0;
    end
  end

  assign cpu_stall = p0_req & ~p0_done;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter with a latency-accurate memory model
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int RD_LAT   = 3;
  localparam int MAX_WAIT = 4;
`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    int          port;
    int          due;
    logic        we;
    logic [31:0] rdata;
  } sb_t;

  logic        im_clk = 1'b0;
  logic        reset  = 1'b1;
  logic        p0_req = 1'b0, p1_req = 1'b0, p0_we = 1'b0, p1_we = 1'b0;
  logic [31:0] p0_addr = '0, p1_addr = '0, p0_wdata = '0, p1_wdata = '0;
  logic        p0_gnt, p1_gnt, p0_done, p1_done, cpu_stall, mem_read, mem_write;
  logic [31:0] p0_rdata, p1_rdata, mem_addr, mem_wdata, mem_rdata;

  dmem_arbiter #(.RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)) dut (
    .im_clk(im_clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_done(p0_done), .p1_done(p1_done),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata), .cpu_stall(cpu_stall),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 im_clk = ~im_clk;

  int cyc = 0;
  always @(posedge im_clk) cyc <= cyc + 1;

  // data_mem model: read data only valid in the RD_LAT-th strobe cycle
  logic [31:0] mem_arr [0:63];
  int          rd_cyc = 0;
  always @(posedge im_clk) begin
    if (mem_write) mem_arr[mem_addr[7:2]] <= mem_wdata;
    rd_cyc <= mem_read ? rd_cyc + 1 : 0;
  end
  assign mem_rdata = (mem_read && rd_cyc == RD_LAT - 1) ? mem_arr[mem_addr[7:2]]
                                                        : (32'hBAD0_0000 | 32'(rd_cyc));

  int          total = 0, bad = 0;
  req_t        q0[$], q1[$];
  sb_t         sb[$];
  int          gord[$];
  logic [31:0] shadow [0:63];
  int          free_cyc = 0, m_wc = 0, m_last = 1;
  logic        cur_valid = 1'b0, cur_we = 1'b0;
  int          cur_t = 0;
  logic [31:0] cur_addr = '0, cur_wdata = '0;
  logic        g0_seen = 1'b0, g1_seen = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    cur_valid = 1'b0;
    free_cyc  = 0;
    m_wc      = 0;
    m_last    = 1;
    g0_seen   = 1'b0;
    g1_seen   = 1'b0;
  endtask

  task automatic drive();
    p0_req = (q0.size() != 0);
    p1_req = (q1.size() != 0);
    p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
    if (p0_req) begin p0_we = q0[0].we; p0_addr = q0[0].addr; p0_wdata = q0[0].wdata; end
    if (p1_req) begin p1_we = q1[0].we; p1_addr = q1[0].addr; p1_wdata = q1[0].wdata; end
  endtask

  task automatic monitor();
    logic e_g0, e_g1, e_d0, e_d1, e_mr, e_mw;
    int   w;
    sb_t  e;
    e_g0 = 1'b0; e_g1 = 1'b0; e_d0 = 1'b0; e_d1 = 1'b0;
    e_mw = cur_valid && cur_we && (cyc == cur_t + 1);
    e_mr = cur_valid && !cur_we && (cyc > cur_t) && (cyc <= cur_t + RD_LAT);
    check("strobes", {30'd0, mem_read, mem_write}, {30'd0, e_mr, e_mw});
    if (e_mr || e_mw) check("mem_addr", mem_addr, cur_addr);
    if (e_mw) check("mem_wdata", mem_wdata, cur_wdata);

    if (sb.size() != 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      if (e.port == 0) e_d0 = 1'b1; else e_d1 = 1'b1;
      if (!e.we) check(e.port == 0 ? "p0_rdata" : "p1_rdata",
                       e.port == 0 ? p0_rdata : p1_rdata, e.rdata);
    end
    check("done", {30'd0, p1_done, p0_done}, {30'd0, e_d1, e_d0});
    check("cpu_stall", {31'd0, cpu_stall}, {31'd0, p0_req & ~e_d0});

    if (cyc >= free_cyc && (p0_req || p1_req)) begin
      if (p0_req && p1_req) w = (m_wc >= MAX_WAIT) ? 1 : (RR ? (m_last == 0 ? 1 : 0) : 0);
      else w = p1_req ? 1 : 0;
      if (w == 0) e_g0 = 1'b1; else e_g1 = 1'b1;
      m_last    = w;
      cur_valid = 1'b1;
      cur_t     = cyc;
      cur_we    = w ? p1_we : p0_we;
      cur_addr  = w ? p1_addr : p0_addr;
      cur_wdata = w ? p1_wdata : p0_wdata;
      if (cur_we) shadow[cur_addr[7:2]] = cur_wdata;
      free_cyc = cyc + (cur_we ? 3 : RD_LAT + 2);
      sb.push_back('{port: w, due: cyc + (cur_we ? 2 : RD_LAT + 1), we: cur_we,
                     rdata: shadow[cur_addr[7:2]]});
    end
    check("gnt", {30'd0, p1_gnt, p0_gnt}, {30'd0, e_g1, e_g0});
    if (p0_gnt) gord.push_back(0);
    if (p1_gnt) gord.push_back(1);
    g0_seen = p0_gnt;
    g1_seen = p1_gnt;
    m_wc = (p1_req && !e_g1) ? ((m_wc < 255) ? m_wc + 1 : 255) : 0;
  endtask

  task automatic step();
    @(posedge im_clk); #1;
    if (g0_seen) q0.delete(0);
    if (g1_seen) q1.delete(0);
    g0_seen = 1'b0;
    g1_seen = 1'b0;
    drive();
    @(negedge im_clk);
    monitor();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || sb.size() != 0) && n < budget) begin
      step();
      n++;
    end
    check("drain_timeout", {31'd0, n >= budget}, 32'd0);
  endtask

  task automatic do_reset();
    @(posedge im_clk); #1;
    reset = 1'b1;
    q0.delete(); q1.delete();
    drive();
    @(negedge im_clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int exp_ord[5];
    int k;
    // reset state
    repeat (2) @(posedge im_clk);
    @(negedge im_clk);
    check("rst_ctl", {25'd0, p0_gnt, p1_gnt, p0_done, p1_done, mem_read, mem_write, cpu_stall}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_p0_rdata", p0_rdata, 32'd0);
    check("rst_p1_rdata", p1_rdata, 32'd0);
    reset = 1'b0;
    model_reset();

    // port-0 write then read back
    q0.push_back('{we: 1'b1, addr: 32'h10, wdata: 32'hDEAD});
    q0.push_back('{we: 1'b0, addr: 32'h10, wdata: 32'h0});
    drain(40);
    check("p0_readback", p0_rdata, 32'hDEAD);

    // port-1 write then multi-cycle read
    q1.push_back('{we: 1'b1, addr: 32'h20, wdata: 32'hCAFEF00D});
    q1.push_back('{we: 1'b0, addr: 32'h20, wdata: 32'h0});
    drain(40);
    check("p1_readback", p1_rdata, 32'hCAFEF00D);

    // CPU request arriving while port 1 owns the memory
    q1.push_back('{we: 1'b0, addr: 32'h20, wdata: 32'h0});
    step();
    q0.push_back('{we: 1'b0, addr: 32'h10, wdata: 32'h0});
    drain(40);

    // continuous contention from a fresh reset
    do_reset();
    gord.delete();
    for (int i = 0; i < 4; i++) begin
      q0.push_back('{we: 1'b1, addr: 32'h40 + 32'(8 * i), wdata: 32'hA000_0000 + 32'(i)});
      q1.push_back('{we: 1'b1, addr: 32'h44 + 32'(8 * i), wdata: 32'hB000_0000 + 32'(i)});
    end
    drain(100);
`ifdef DMEM_ARB_RR_EN
    exp_ord = '{0, 1, 0, 1, 0};
`else
    exp_ord = '{0, 0, 1, 0, 1};
`endif
    check("grant_count", gord.size(), 32'd8);
    for (int i = 0; i < 5; i++) check($sformatf("grant_order%0d", i), gord[i], exp_ord[i]);
    for (int i = 0; i < 4; i++) begin
      q0.push_back('{we: 1'b0, addr: 32'h44 + 32'(8 * i), wdata: 32'h0});
      q1.push_back('{we: 1'b0, addr: 32'h40 + 32'(8 * i), wdata: 32'h0});
    end
    drain(120);

    // reset in the middle of a multi-cycle read
    q1.push_back('{we: 1'b0, addr: 32'h20, wdata: 32'h0});
    k = 0;
    while (!g1_seen && k < 20) begin step(); k++; end
    check("wait_gnt", {31'd0, g1_seen}, 32'd1);
    step();
    step();
    #1 reset = 1'b1;
    #1;
    check("rst_wait_strobe", {30'd0, mem_read, mem_write}, 32'd0);
    check("rst_wait_done", {30'd0, p1_done, p0_done}, 32'd0);
    @(negedge im_clk);
    check("rst_wait_rdata", p1_rdata, 32'd0);
    reset = 1'b0;
    model_reset();
    q1.delete();
    q1.push_back('{we: 1'b0, addr: 32'h20, wdata: 32'h0});
    drain(40);
    check("rereq_rdata", p1_rdata, 32'hCAFEF00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
